// File: rtl/wb_dbg_arb_pkg.sv
// Shared definitions for the Wishbone debug-port arbiter.
// FSM encoding, error data word and CTRL register layout.
package wb_dbg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        CTRL_ACC,
        RESP
    } state_t;

    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    localparam int CTRL_HOLD_LSB = 0;
    localparam int CTRL_TO_BIT   = 31;

endpackage

// File: rtl/wb_dbg_core_arbiter.sv
// Shares one Wishbone slave port among N_CORES debug ports.
// Also owns the CTRL register (per-core reset holds, sticky timeout).
module wb_dbg_core_arbiter
    import wb_dbg_arb_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int SEL_LSB = 24,
    parameter int TIMEOUT = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [31:0]          i_wb_adr,
    input  logic [31:0]          i_wb_dat,
    input  logic [3:0]           i_wb_sel,
    input  logic                 i_wb_we,
    input  logic                 i_wb_stb,
    input  logic                 i_wb_cyc,
    output logic [31:0]          o_wb_rdt,
    output logic                 o_wb_ack,
    output logic [31:0]          o_core_adr,
    output logic [31:0]          o_core_dat,
    output logic [3:0]           o_core_sel,
    output logic                 o_core_we,
    output logic [N_CORES-1:0]   o_core_stb,
    input  logic [32*N_CORES-1:0] i_core_rdt,
    input  logic [N_CORES-1:0]   i_core_ack,
    output logic [N_CORES-1:0]   o_core_rst,
    output logic                 o_timeout
);

    localparam int IDXW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int CW   = $clog2(TIMEOUT + 1);

    state_t              state;
    logic [IDXW-1:0]     idx;
    logic [CW-1:0]       cnt;
    logic [N_CORES-1:0]  hold;
    logic                bad;

    logic                hit_ctrl;
    logic [IDXW-1:0]     hit_idx;
    logic                idx_bad;
    logic                ack_sel;
    logic [31:0]         rdt_sel;
    logic [N_CORES-1:0]  hold_nx;
    logic                to_nx;
    logic [31:0]         ctrl_word;

    assign hit_ctrl = i_wb_adr[SEL_LSB+IDXW];
    assign hit_idx  = i_wb_adr[SEL_LSB +: IDXW];
    assign idx_bad  = ({{(32-IDXW){1'b0}}, hit_idx} >= 32'(N_CORES))
                    || hold[hit_idx];
    assign ack_sel  = i_core_ack[idx];
    assign rdt_sel  = i_core_rdt[32*idx +: 32];

    assign o_core_rst = {N_CORES{i_rst}} | hold;

    // CTRL reads return the register contents after this access's write
    always_comb begin
        hold_nx   = hold;
        to_nx     = o_timeout;
        ctrl_word = '0;
        if (o_core_we && o_core_sel[0])
            hold_nx = o_core_dat[N_CORES-1:0];
        if (o_core_we && o_core_dat[CTRL_TO_BIT])
            to_nx = 1'b0;
        ctrl_word[CTRL_HOLD_LSB +: N_CORES] = hold_nx;
        ctrl_word[CTRL_TO_BIT] = to_nx;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            hold       <= '1;
            bad        <= 1'b0;
            o_timeout  <= 1'b0;
            o_wb_rdt   <= '0;
            o_wb_ack   <= 1'b0;
            o_core_adr <= '0;
            o_core_dat <= '0;
            o_core_sel <= '0;
            o_core_we  <= 1'b0;
            o_core_stb <= '0;
        end else begin
            o_wb_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_wb_stb && i_wb_cyc && !o_wb_ack) begin
                        o_core_adr <= i_wb_adr;
                        o_core_dat <= i_wb_dat;
                        o_core_sel <= i_wb_sel;
                        o_core_we  <= i_wb_we;
                        idx        <= hit_idx;
                        cnt        <= '0;
                        // error accesses share CTRL_ACC's extra cycle
                        if (hit_ctrl) begin
                            bad   <= 1'b0;
                            state <= CTRL_ACC;
                        end else if (idx_bad) begin
                            bad   <= 1'b1;
                            state <= CTRL_ACC;
                        end else begin
                            o_core_stb <= N_CORES'(1) << hit_idx;
                            state      <= FWD;
                        end
                    end
                end
                FWD: begin
                    if (!i_wb_cyc) begin
                        o_core_stb <= '0;
                        state      <= IDLE;
                    end else if (ack_sel) begin
                        o_wb_rdt   <= rdt_sel;
                        o_wb_ack   <= 1'b1;
                        o_core_stb <= '0;
                        state      <= RESP;
                    end else if (cnt == CW'(TIMEOUT)) begin
                        o_wb_rdt   <= ERR_DATA;
                        o_wb_ack   <= 1'b1;
                        o_timeout  <= 1'b1;
                        o_core_stb <= '0;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CTRL_ACC: begin
                    if (bad) begin
                        o_wb_rdt <= ERR_DATA;
                    end else begin
                        hold      <= hold_nx;
                        o_timeout <= to_nx;
                        o_wb_rdt  <= ctrl_word;
                    end
                    o_wb_ack <= 1'b1;
                    state    <= RESP;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_dbg_core_arbiter.sv
// Bench for wb_dbg_core_arbiter: vector table, corner sequences,
// then random traffic against a transaction-level reference model.
module tb_wb_dbg_core_arbiter;

    localparam int TIMEOUT = 255;
    localparam int NEVER   = 1000;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        bit          we;
        int          clat;
        logic [31:0] crdt;
        logic [3:0]  noise;
        logic [31:0] exp_rdt;
        int          exp_lat;
        logic [3:0]  exp_seen;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  wb_adr, wb_dat;
    logic [3:0]   wb_sel;
    logic         wb_we, wb_stb, wb_cyc;
    logic [31:0]  wb_rdt;
    logic         wb_ack;
    logic [31:0]  core_adr, core_dat;
    logic [3:0]   core_sel;
    logic         core_we;
    logic [3:0]   core_stb;
    logic [127:0] core_rdt;
    logic [3:0]   core_ack;
    logic [3:0]   core_rst;
    logic         timeout;

    int          n_chk = 0;
    int          n_fail = 0;
    int          clat_g = 0;
    logic [3:0]  noise_g = '0;
    int          wcnt[4];
    logic [3:0]  m_hold;
    logic        m_to;
    vec_t        tbl[12];

    wb_dbg_core_arbiter dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wb_adr   (wb_adr),
        .i_wb_dat   (wb_dat),
        .i_wb_sel   (wb_sel),
        .i_wb_we    (wb_we),
        .i_wb_stb   (wb_stb),
        .i_wb_cyc   (wb_cyc),
        .o_wb_rdt   (wb_rdt),
        .o_wb_ack   (wb_ack),
        .o_core_adr (core_adr),
        .o_core_dat (core_dat),
        .o_core_sel (core_sel),
        .o_core_we  (core_we),
        .o_core_stb (core_stb),
        .i_core_rdt (core_rdt),
        .i_core_ack (core_ack),
        .o_core_rst (core_rst),
        .o_timeout  (timeout)
    );

    always #5 clk = ~clk;

    // Core model: acks clat_g cycles after its strobe is first seen
    initial core_ack = '0;
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            wcnt[i] <= core_stb[i] ? wcnt[i] + 1 : 0;
            core_ack[i] <= (core_stb[i] && wcnt[i] == clat_g) | noise_g[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model of what the host should observe
    task automatic model(input logic [31:0] adr, dat, input logic [3:0] sel,
                         input bit we, input int clat, input logic [31:0] crdt,
                         output logic [31:0] er, output int el,
                         output logic [3:0] es);
        int k;
        k  = int'(adr[25:24]);
        es = '0;
        el = 2;
        if (adr[26]) begin
            if (we && sel[0]) m_hold = dat[3:0];
            if (we && dat[31]) m_to = 1'b0;
            er = {m_to, 27'b0, m_hold};
        end else if (m_hold[k]) begin
            er = ERR;
        end else begin
            es = 4'b0001 << k;
            if (clat > TIMEOUT) begin
                er   = ERR;
                el   = TIMEOUT + 2;
                m_to = 1'b1;
            end else begin
                er = crdt;
                el = clat + 2;
            end
        end
    endtask

    task automatic run(input vec_t v, input bit use_model, input string tag);
        logic [31:0] mr, rdt;
        int          ml, lat, acks;
        logic [3:0]  ms, seen;
        bit          fwd_ok, done;
        int          tgt;
        model(v.adr, v.dat, v.sel, v.we, v.clat, v.crdt, mr, ml, ms);
        if (use_model) begin
            v.exp_rdt  = mr;
            v.exp_lat  = ml;
            v.exp_seen = ms;
        end
        tgt    = int'(v.adr[25:24]);
        clat_g = v.clat;
        for (int i = 0; i < 4; i++)
            core_rdt[32*i +: 32] = (i == tgt) ? v.crdt : ~v.crdt ^ 32'(i);
        noise_g = v.noise;
        wb_adr = v.adr;
        wb_dat = v.dat;
        wb_sel = v.sel;
        wb_we  = v.we;
        wb_stb = 1'b1;
        wb_cyc = 1'b1;
        lat = -1; acks = 0; seen = '0; fwd_ok = 1'b1; done = 1'b0;
        rdt = '0;
        for (int j = 0; j < TIMEOUT + 20 && !done; j++) begin
            @(posedge clk);
            #1;
            if (core_stb != '0) begin
                seen |= core_stb;
                if (!$onehot(core_stb) || core_adr !== v.adr
                    || core_dat !== v.dat || core_sel !== v.sel
                    || core_we !== v.we)
                    fwd_ok = 1'b0;
            end
            if (wb_ack) begin
                acks++;
                if (lat < 0) begin
                    lat = j + 1;
                    rdt = wb_rdt;
                end
            end
            if (lat >= 0 && j == lat) begin
                wb_stb = 1'b0;
                wb_cyc = 1'b0;
            end
            if (lat >= 0 && j >= lat + 2) done = 1'b1;
        end
        wb_stb  = 1'b0;
        wb_cyc  = 1'b0;
        noise_g = '0;
        chk({tag, "_rdt"},  rdt, v.exp_rdt);
        chk({tag, "_lat"},  32'(lat), 32'(v.exp_lat));
        chk({tag, "_acks"}, 32'(acks), 32'd1);
        chk({tag, "_stb"},  {28'b0, seen}, {28'b0, v.exp_seen});
        chk({tag, "_fwd"},  {31'b0, fwd_ok}, 32'd1);
        chk({tag, "_rst"},  {28'b0, core_rst}, {28'b0, m_hold});
        chk({tag, "_tmo"},  {31'b0, timeout}, {31'b0, m_to});
    endtask

    task automatic idle_acks(input int n, input string name);
        int acks;
        acks = 0;
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
            if (wb_ack) acks++;
        end
        chk(name, 32'(acks), 32'd0);
    endtask

    initial begin
        vec_t v;
        int   r;
        //        adr            dat            sel    we clat     crdt           noise   exp_rdt        lat  seen
        tbl[0]  = '{32'h0400_0000, 32'h0000_0000, 4'hF, 1, 0,       32'h0,         4'h0,   32'h0000_0000, 2,   4'h0};
        tbl[1]  = '{32'h0200_0010, 32'h1234_5678, 4'hF, 1, 3,       32'h0,         4'h0,   32'h0000_0000, 5,   4'h4};
        tbl[2]  = '{32'h0100_0000, 32'h0,         4'hF, 0, 1,       32'hCAFE_F00D, 4'hD,   32'hCAFE_F00D, 3,   4'h2};
        tbl[3]  = '{32'h0300_0000, 32'h0,         4'hF, 0, NEVER,   32'h1357_9BDF, 4'h0,   ERR,           257, 4'h8};
        tbl[4]  = '{32'h0400_0000, 32'h0,         4'hF, 0, 0,       32'h0,         4'h0,   32'h8000_0000, 2,   4'h0};
        tbl[5]  = '{32'h0400_0000, 32'h8000_0001, 4'h1, 1, 0,       32'h0,         4'h0,   32'h0000_0001, 2,   4'h0};
        tbl[6]  = '{32'h0000_0004, 32'h0,         4'hF, 0, 0,       32'h1111_1111, 4'h0,   ERR,           2,   4'h0};
        tbl[7]  = '{32'h0400_0000, 32'h0000_000E, 4'hE, 1, 0,       32'h0,         4'h0,   32'h0000_0001, 2,   4'h0};
        tbl[8]  = '{32'h0400_0000, 32'h0000_0000, 4'h1, 1, 0,       32'h0,         4'h0,   32'h0000_0000, 2,   4'h0};
        tbl[9]  = '{32'h0000_0008, 32'h0,         4'hF, 0, 0,       32'h0BAD_F00D, 4'hE,   32'h0BAD_F00D, 2,   4'h1};
        tbl[10] = '{32'h0100_0000, 32'h0,         4'hF, 0, TIMEOUT, 32'h7777_0001, 4'h0,   32'h7777_0001, 257, 4'h2};
        tbl[11] = '{32'hFC00_0000, 32'h0,         4'hF, 0, 0,       32'h0,         4'h0,   32'h0000_0000, 2,   4'h0};

        for (int i = 0; i < 128; i++) core_rdt[i] = 1'b0;
        rst = 1'b1;
        wb_adr = '0; wb_dat = '0; wb_sel = '0;
        wb_we = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_core_rst", {28'b0, core_rst}, 32'h0000_000F);
        chk("reset_stb",      {28'b0, core_stb}, 32'h0);
        chk("reset_ack",      {31'b0, wb_ack},   32'h0);
        chk("reset_rdt",      wb_rdt,            32'h0);
        chk("reset_tmo",      {31'b0, timeout},  32'h0);
        rst    = 1'b0;
        m_hold = 4'hF;
        m_to   = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++)
            run(tbl[i], 1'b0, $sformatf("vec%0d", i));

        // Host abort while a core is stalling
        clat_g = NEVER;
        wb_adr = 32'h0200_0000; wb_we = 1'b0; wb_sel = 4'hF;
        wb_stb = 1'b1; wb_cyc = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_stb_on", {28'b0, core_stb}, 32'h0000_0004);
        wb_stb = 1'b0; wb_cyc = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_stb_off", {28'b0, core_stb}, 32'h0);
        idle_acks(6, "abort_no_ack");
        v = '{32'h0200_0000, 32'h0, 4'hF, 0, 1, 32'hA5A5_0202, 4'h0, 32'h0, 0, 4'h0};
        run(v, 1'b1, "after_abort");

        // Asynchronous reset in the middle of a forwarded access
        clat_g = NEVER;
        wb_adr = 32'h0100_0000; wb_stb = 1'b1; wb_cyc = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rstfwd_stb_on", {28'b0, core_stb}, 32'h0000_0002);
        rst = 1'b1;
        #1;
        chk("rstfwd_stb",  {28'b0, core_stb}, 32'h0);
        chk("rstfwd_core", {28'b0, core_rst}, 32'h0000_000F);
        wb_stb = 1'b0; wb_cyc = 1'b0;
        @(posedge clk);
        #1;
        chk("rstfwd_ack", {31'b0, wb_ack}, 32'h0);
        rst    = 1'b0;
        m_hold = 4'hF;
        m_to   = 1'b0;
        idle_acks(3, "rstfwd_no_ack");
        v = '{32'h0400_0000, 32'h0, 4'hF, 1, 0, 32'h0, 4'h0, 32'h0, 0, 4'h0};
        run(v, 1'b1, "rstfwd_ctrl");
        v = '{32'h0100_0000, 32'h0, 4'hF, 0, 2, 32'h55AA_0101, 4'h0, 32'h0, 0, 4'h0};
        run(v, 1'b1, "rstfwd_core1");

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 4);
            v.adr = $urandom;
            if (r == 4) begin
                v.adr[26] = 1'b1;
                v.noise   = 4'($urandom);
            end else begin
                v.adr[26]    = 1'b0;
                v.adr[25:24] = 2'(r);
                v.noise      = 4'($urandom) & ~(4'b0001 << r);
            end
            v.dat  = $urandom;
            v.sel  = 4'($urandom);
            v.we   = 1'($urandom);
            v.clat = ($urandom_range(0, 9) == 0) ? NEVER
                                                  : int'($urandom_range(0, 4));
            v.crdt = $urandom;
            run(v, 1'b1, $sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
